// File: rtl/alu_rsp_deser.sv
// Serial ALU response receiver: deserialises 11-bit packets from sout, rebuilds
// frames and holds one decoded response. Optional CRC check: ALU_RSP_CRC_CHECK_EN.
module alu_rsp_deser #(
  parameter int DATA_BYTES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sout,
  input  logic                    rsp_ready,
  output logic                    rsp_valid,
  output logic [8*DATA_BYTES-1:0] rsp_data,
  output logic [3:0]              rsp_flags,
  output logic [2:0]              rsp_crc,
  output logic                    rsp_is_err,
  output logic [2:0]              rsp_err_flags,
  output logic                    rsp_crc_ok,
  output logic                    rsp_frame_err,
  output logic                    ovf
);

  localparam int W  = 8 * DATA_BYTES;
  localparam int CW = $clog2(DATA_BYTES + 1);
  localparam logic [CW-1:0] FULL = CW'(DATA_BYTES);

  typedef enum logic {IDLE, RECV} state_t;

  state_t      state;
  logic [3:0]  bit_cnt;
  logic [8:0]  shreg;
  logic        pkt_valid;
  logic        pkt_type;
  logic        pkt_stop;
  logic [7:0]  pkt_payload;

  // Counter 0..8 captures type and payload; at 9 the stop bit is on sout.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      shreg       <= '0;
      pkt_valid   <= 1'b0;
      pkt_type    <= 1'b0;
      pkt_stop    <= 1'b0;
      pkt_payload <= '0;
    end else begin
      pkt_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (!sout) begin
            state   <= RECV;
            bit_cnt <= '0;
          end
        end
        RECV: begin
          if (bit_cnt == 4'd9) begin
            state       <= IDLE;
            pkt_valid   <= 1'b1;
            pkt_type    <= shreg[8];
            pkt_payload <= shreg[7:0];
            pkt_stop    <= sout;
          end else begin
            shreg   <= {shreg[7:0], sout};
            bit_cnt <= bit_cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_RSP_CRC_CHECK_EN
  // x^3+x+1, init 0, message shifted in MSB first.
  function automatic logic [2:0] crc3(input logic [W+4:0] msg);
    logic [2:0] c;
    logic       fb;
    c = 3'b000;
    for (int i = W + 4; i >= 0; i--) begin
      fb = msg[i] ^ c[2];
      c  = {c[1], c[0] ^ fb, fb};
    end
    return c;
  endfunction
`endif

  logic [CW-1:0] data_cnt;
  logic [W-1:0]  data_q;

  logic          frame_done;
  logic [W-1:0]  f_data;
  logic [3:0]    f_flags;
  logic [2:0]    f_crc;
  logic          f_is_err;
  logic [2:0]    f_err_flags;
  logic          f_crc_ok;
  logic          f_frame_err;

  always_comb begin
    frame_done  = 1'b0;
    f_data      = '0;
    f_flags     = '0;
    f_crc       = '0;
    f_is_err    = 1'b0;
    f_err_flags = '0;
    f_frame_err = 1'b0;
    if (pkt_valid) begin
      if (!pkt_stop) begin
        frame_done  = 1'b1;
        f_data      = data_q;
        f_frame_err = 1'b1;
      end else if (!pkt_type) begin
        if (data_cnt == FULL) begin
          frame_done  = 1'b1;
          f_data      = data_q;
          f_frame_err = 1'b1;
        end
      end else if (!pkt_payload[7]) begin
        frame_done  = 1'b1;
        f_data      = data_q;
        f_flags     = pkt_payload[6:3];
        f_crc       = pkt_payload[2:0];
        f_frame_err = (data_cnt != FULL);
      end else begin
        frame_done  = 1'b1;
        f_is_err    = 1'b1;
        f_err_flags = pkt_payload[6:4];
        f_frame_err = (data_cnt != '0) || (pkt_payload[6:4] != pkt_payload[3:1]) ||
                      (pkt_payload[0] != ^{1'b1, pkt_payload[6:4], pkt_payload[3:1]});
      end
    end
`ifdef ALU_RSP_CRC_CHECK_EN
    f_crc_ok = f_is_err || (crc3({f_data, 1'b0, f_flags}) == f_crc);
`else
    f_crc_ok = 1'b1;
`endif
  end

  // Bytes are placed by arrival index so missing trailing bytes stay zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_cnt <= '0;
      data_q   <= '0;
    end else if (frame_done) begin
      data_cnt <= '0;
      data_q   <= '0;
    end else if (pkt_valid && pkt_stop && !pkt_type) begin
      for (int i = 0; i < DATA_BYTES; i++) begin
        if (data_cnt == CW'(i)) data_q[8*(DATA_BYTES-1-i) +: 8] <= pkt_payload;
      end
      data_cnt <= data_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid     <= 1'b0;
      rsp_data      <= '0;
      rsp_flags     <= '0;
      rsp_crc       <= '0;
      rsp_is_err    <= 1'b0;
      rsp_err_flags <= '0;
      rsp_crc_ok    <= 1'b0;
      rsp_frame_err <= 1'b0;
      ovf           <= 1'b0;
    end else begin
      ovf <= 1'b0;
      if (frame_done) begin
        if (!rsp_valid || rsp_ready) begin
          rsp_valid     <= 1'b1;
          rsp_data      <= f_data;
          rsp_flags     <= f_flags;
          rsp_crc       <= f_crc;
          rsp_is_err    <= f_is_err;
          rsp_err_flags <= f_err_flags;
          rsp_crc_ok    <= f_crc_ok;
          rsp_frame_err <= f_frame_err;
        end else begin
          ovf <= 1'b1;
        end
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_rsp_deser.sv
// Self-checking bench for alu_rsp_deser: serial packet driver, response
// scoreboard, scenario tasks and a one-line report.
module tb_alu_rsp_deser;
  localparam int DB = 4;
  localparam int W  = 8 * DB;
  localparam int EW = W + 13;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sout = 1'b1;
  logic          rsp_ready = 1'b1;
  logic          rsp_valid;
  logic [W-1:0]  rsp_data;
  logic [3:0]    rsp_flags;
  logic [2:0]    rsp_crc;
  logic          rsp_is_err;
  logic [2:0]    rsp_err_flags;
  logic          rsp_crc_ok;
  logic          rsp_frame_err;
  logic          ovf;

  int total = 0;
  int bad = 0;
  int ovf_seen = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] act;
  logic rand_done;

  alu_rsp_deser #(.DATA_BYTES(DB)) dut (
    .clk(clk), .rst(rst), .sout(sout), .rsp_ready(rsp_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_flags(rsp_flags),
    .rsp_crc(rsp_crc), .rsp_is_err(rsp_is_err), .rsp_err_flags(rsp_err_flags),
    .rsp_crc_ok(rsp_crc_ok), .rsp_frame_err(rsp_frame_err), .ovf(ovf)
  );

  always #5 clk = ~clk;

  assign act = {rsp_data, rsp_flags, rsp_crc, rsp_is_err, rsp_err_flags, rsp_crc_ok, rsp_frame_err};

  // Scoreboard: every handshake pops one expected response.
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (!rst) begin
      if (ovf) ovf_seen++;
      if (rsp_valid && rsp_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_rsp got=%h want=none", act);
        end else begin
          e = exp_q.pop_front();
          if (act !== e) begin
            bad++;
            $display("FAIL rsp_fields got=%h want=%h", act, e);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=running want=finished");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  // Long division of {data,0,flags} * x^3 by x^3+x+1.
  function automatic logic [2:0] crc_model(input logic [W-1:0] d, input logic [3:0] f);
    logic [W+7:0] r;
    r = {d, 1'b0, f, 3'b000};
    for (int i = W + 7; i >= 3; i--) if (r[i]) r[i-:4] = r[i-:4] ^ 4'b1011;
    return r[2:0];
  endfunction

  function automatic logic crc_ok_model(input logic [W-1:0] d, input logic [3:0] f, input logic [2:0] c);
`ifdef ALU_RSP_CRC_CHECK_EN
    return crc_model(d, f) == c;
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [EW-1:0] exp_rsp(input logic [W-1:0] d, input logic [3:0] f,
      input logic [2:0] c, input logic is_err, input logic [2:0] ef, input logic ok, input logic ferr);
    return {d, f, c, is_err, ef, ok, ferr};
  endfunction

  task automatic send_pkt(input logic typ, input logic [7:0] pl, input logic stop);
    logic [10:0] bits;
    bits = {1'b0, typ, pl, stop};
    for (int i = 10; i >= 0; i--) begin
      @(posedge clk); #1;
      sout = bits[i];
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      sout = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [W-1:0] d, input logic [3:0] f, input logic [2:0] c);
    for (int i = 0; i < DB; i++) send_pkt(1'b0, d[W-1-8*i -: 8], 1'b1);
    send_pkt(1'b1, {1'b0, f, c}, 1'b1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge clk);
    @(posedge clk); #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d want=0 pending", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", rsp_valid); end
    total++;
    if (act !== '0) begin bad++; $display("FAIL reset_fields got=%h want=0", act); end
    total++;
    if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", ovf); end
    rst = 1'b0;
  endtask

  task automatic test_success();
    exp_q.push_back(exp_rsp('0, 4'b1010, 3'b011, 1'b0, 3'b000, crc_ok_model('0, 4'b1010, 3'b011), 1'b0));
    send_frame('0, 4'b1010, 3'b011);
    @(posedge clk); #1;
    total++;
    if (rsp_valid !== 1'b0) begin bad++; $display("FAIL latency_early got=%b want=0", rsp_valid); end
    @(posedge clk); #1;
    total++;
    if (rsp_valid !== 1'b1) begin bad++; $display("FAIL latency_on_time got=%b want=1", rsp_valid); end
    wait_drain();
  endtask

  task automatic test_bad_crc();
    exp_q.push_back(exp_rsp('0, 4'b1010, 3'b010, 1'b0, 3'b000, crc_ok_model('0, 4'b1010, 3'b010), 1'b0));
    send_frame('0, 4'b1010, 3'b010);
    idle(2);
    wait_drain();
  endtask

  task automatic test_err_pkt();
    exp_q.push_back(exp_rsp('0, 4'b0, 3'b0, 1'b1, 3'b001, 1'b1, 1'b0));
    send_pkt(1'b1, 8'h93, 1'b1);
    idle(3);
    exp_q.push_back(exp_rsp('0, 4'b0, 3'b0, 1'b1, 3'b000, 1'b1, 1'b1));
    send_pkt(1'b1, 8'h8B, 1'b1);
    idle(3);
    wait_drain();
  endtask

  task automatic test_framing();
    exp_q.push_back(exp_rsp(32'hAABBCC00, 4'b1010, 3'b011, 1'b0, 3'b000,
                            crc_ok_model(32'hAABBCC00, 4'b1010, 3'b011), 1'b1));
    send_pkt(1'b0, 8'hAA, 1'b1);
    send_pkt(1'b0, 8'hBB, 1'b1);
    send_pkt(1'b0, 8'hCC, 1'b1);
    send_pkt(1'b1, 8'h53, 1'b1);
    idle(3);
    wait_drain();
    // Bad stop bit ends the frame on the spot, keeping the two stored bytes.
    exp_q.push_back(exp_rsp(32'h11220000, 4'b0, 3'b0, 1'b0, 3'b000,
                            crc_ok_model(32'h11220000, 4'b0, 3'b0), 1'b1));
    send_pkt(1'b0, 8'h11, 1'b1);
    send_pkt(1'b0, 8'h22, 1'b1);
    send_pkt(1'b0, 8'h33, 1'b0);
    @(posedge clk); #1;
    sout = 1'b1;
    total++;
    if (rsp_valid !== 1'b0) begin bad++; $display("FAIL stop_err_early got=%b want=0", rsp_valid); end
    @(posedge clk); #1;
    total++;
    if (rsp_valid !== 1'b1) begin bad++; $display("FAIL stop_err_valid got=%b want=1", rsp_valid); end
    idle(2);
    wait_drain();
    // Fifth data packet overruns the frame.
    exp_q.push_back(exp_rsp(32'h01020304, 4'b0, 3'b0, 1'b0, 3'b000,
                            crc_ok_model(32'h01020304, 4'b0, 3'b0), 1'b1));
    for (int i = 1; i <= 5; i++) send_pkt(1'b0, 8'(i), 1'b1);
    idle(3);
    wait_drain();
  endtask

  task automatic test_backpressure();
    int base;
    base = ovf_seen;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    exp_q.push_back(exp_rsp(32'hDEADBEEF, 4'b0001, 3'b101, 1'b0, 3'b000,
                            crc_ok_model(32'hDEADBEEF, 4'b0001, 3'b101), 1'b0));
    send_frame(32'hDEADBEEF, 4'b0001, 3'b101);
    send_frame(32'h12345678, 4'b0110, 3'b000);
    idle(4);
    total++;
    if (ovf_seen - base !== 1) begin bad++; $display("FAIL bp_ovf_cycles got=%0d want=1", ovf_seen - base); end
    total++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'hDEADBEEF) begin
      bad++; $display("FAIL bp_held got=%b/%h want=1/deadbeef", rsp_valid, rsp_data);
    end
    rsp_ready = 1'b1;
    wait_drain();
    total++;
    if (rsp_valid !== 1'b0) begin bad++; $display("FAIL bp_release got=%b want=0", rsp_valid); end
  endtask

  task automatic test_back_to_back();
    int base;
    base = ovf_seen;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    exp_q.push_back(exp_rsp(32'hCAFE0001, 4'b1100, 3'b001, 1'b0, 3'b000,
                            crc_ok_model(32'hCAFE0001, 4'b1100, 3'b001), 1'b0));
    exp_q.push_back(exp_rsp(32'hCAFE0002, 4'b0011, 3'b110, 1'b0, 3'b000,
                            crc_ok_model(32'hCAFE0002, 4'b0011, 3'b110), 1'b0));
    send_frame(32'hCAFE0001, 4'b1100, 3'b001);
    send_frame(32'hCAFE0002, 4'b0011, 3'b110);
    // Handshake lands on the same edge the second frame completes.
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    idle(3);
    wait_drain();
    total++;
    if (ovf_seen - base !== 0) begin bad++; $display("FAIL b2b_ovf got=%0d want=0", ovf_seen - base); end
  endtask

  task automatic test_reset_mid_frame();
    int base;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    send_frame(32'h55555555, 4'b0000, 3'b000);
    idle(2);
    total++;
    if (rsp_valid !== 1'b1) begin bad++; $display("FAIL rst_pre_held got=%b want=1", rsp_valid); end
    send_pkt(1'b0, 8'h77, 1'b1);
    send_pkt(1'b0, 8'h88, 1'b1);
    send_pkt(1'b0, 8'h99, 1'b1);
    rst = 1'b1;
    idle(2);
    total++;
    if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_discard got=%b want=0", rsp_valid); end
    rst = 1'b0;
    rsp_ready = 1'b1;
    base = ovf_seen;
    exp_q.push_back(exp_rsp(32'h0A0B0C0D, 4'b1001, 3'b111, 1'b0, 3'b000,
                            crc_ok_model(32'h0A0B0C0D, 4'b1001, 3'b111), 1'b0));
    send_frame(32'h0A0B0C0D, 4'b1001, 3'b111);
    idle(3);
    wait_drain();
    total++;
    if (ovf_seen - base !== 0) begin bad++; $display("FAIL rst_ovf got=%0d want=0", ovf_seen - base); end
  endtask

  task automatic test_random();
    int base;
    base = ovf_seen;
    rand_done = 1'b0;
    fork
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          rsp_ready = 1'($urandom_range(0, 1));
        end
      end
      begin
        for (int n = 0; n < 8; n++) begin
          logic [W-1:0] d;
          logic [3:0]   f;
          logic [2:0]   c;
          d = $urandom;
          f = 4'($urandom_range(0, 15));
          c = ($urandom_range(0, 1) == 1) ? crc_model(d, f) : 3'($urandom_range(0, 7));
          exp_q.push_back(exp_rsp(d, f, c, 1'b0, 3'b000, crc_ok_model(d, f, c), 1'b0));
          send_frame(d, f, c);
          idle($urandom_range(0, 3));
        end
        idle(4);
        rand_done = 1'b1;
      end
    join
    rsp_ready = 1'b1;
    wait_drain();
    total++;
    if (ovf_seen - base !== 0) begin bad++; $display("FAIL rand_ovf got=%0d want=0", ovf_seen - base); end
  endtask

  initial begin
    test_reset();
    test_success();
    test_bad_crc();
    test_err_pkt();
    test_framing();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
